// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor plus tagged BTB. Prediction is combinational, with zero cycles of latency.
// Training becomes visible to fetch two edges after upd_valid. There is no backpressure, and every update is accepted.
module gshare_btb_predictor #(
  parameter int S_BHR = 8,
  parameter int S_IDX = 10,
  parameter int S_BTB = 6,
  parameter int TAG_W = 8,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  input  logic             if_advance,
  output logic [31:0]      if_pred_pc,
  output logic             if_pred_taken,
  output logic [S_BHR-1:0] if_pred_hist,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic [31:0]      upd_next_pc,
  input  logic             upd_is_cond,
  input  logic [S_BHR-1:0] upd_hist,
  input  logic             upd_mispred
);

  localparam int N_PHT = 1 << S_IDX;
  localparam int N_BTB = 1 << S_BTB;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;

  if (S_BHR > S_IDX) begin : g_bad_bhr
    $error("gshare_btb_predictor: S_BHR must not exceed S_IDX");
  end
  if (CTR_W < 2) begin : g_bad_ctr
    $error("gshare_btb_predictor: CTR_W must be at least 2");
  end

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic [31:0]      tgt;
    logic             cond;
  } btb_entry_t;

  logic [CTR_W-1:0] pht [N_PHT];
  btb_entry_t       btb [N_BTB];

  logic [S_BHR-1:0] spec_hist;
  logic [S_BHR-1:0] commit_hist;

  // Fetch-side lookup
  logic [S_IDX-1:0] f_pht_idx;
  logic [S_BTB-1:0] f_btb_idx;
  btb_entry_t       f_entry;
  logic             f_hit;

  assign f_pht_idx     = if_pc[S_IDX+1:2] ^ S_IDX'(spec_hist);
  assign f_btb_idx     = if_pc[S_BTB+1:2];
  assign f_entry       = btb[f_btb_idx];
  assign f_hit         = f_entry.vld && (f_entry.tag == if_pc[S_BTB+TAG_W+1:S_BTB+2]);
  assign if_pred_taken = f_hit && (!f_entry.cond || pht[f_pht_idx][CTR_W-1]);
  assign if_pred_pc    = if_pred_taken ? f_entry.tgt : if_pc + 32'd4;
  assign if_pred_hist  = spec_hist;

  // Write stage (N+1) registers
  logic             w_pht_en;
  logic [S_IDX-1:0] w_pht_idx;
  logic [CTR_W-1:0] w_ctr;
  logic             w_btb_en;
  logic [S_BTB-1:0] w_btb_idx;
  btb_entry_t       w_entry;

  // Read stage (N)
  logic             u_taken;
  logic [S_IDX-1:0] u_pht_idx;
  logic [CTR_W-1:0] u_ctr_old;
  logic [CTR_W-1:0] u_ctr_new;
  logic [S_BHR-1:0] u_commit_next;

  assign u_taken   = upd_next_pc != (upd_pc + 32'd4);
  assign u_pht_idx = upd_pc[S_IDX+1:2] ^ S_IDX'(upd_hist);

  // A write still pending in N+1 to the same counter is newer than the array
  assign u_ctr_old = (w_pht_en && (w_pht_idx == u_pht_idx)) ? w_ctr : pht[u_pht_idx];

  always_comb begin
    u_ctr_new = u_ctr_old;
    if (u_taken) begin
      if (u_ctr_old != CTR_MAX) u_ctr_new = u_ctr_old + CTR_W'(1);
    end else begin
      if (u_ctr_old != '0) u_ctr_new = u_ctr_old - CTR_W'(1);
    end
  end

  assign u_commit_next = upd_is_cond ? S_BHR'({commit_hist, u_taken}) : commit_hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_pht_en  <= 1'b0;
      w_pht_idx <= '0;
      w_ctr     <= '0;
      w_btb_en  <= 1'b0;
      w_btb_idx <= '0;
      w_entry   <= '0;
    end else begin
      w_pht_en  <= upd_valid && upd_is_cond;
      w_pht_idx <= u_pht_idx;
      w_ctr     <= u_ctr_new;
      w_btb_en  <= upd_valid && u_taken;
      w_btb_idx <= upd_pc[S_BTB+1:2];
      w_entry   <= '{vld: 1'b1, tag: upd_pc[S_BTB+TAG_W+1:S_BTB+2], tgt: upd_next_pc, cond: upd_is_cond};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_PHT; i++) pht[i] <= CTR_INIT;
    end else if (w_pht_en) begin
      pht[w_pht_idx] <= w_ctr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTB; i++) btb[i] <= '0;
    end else if (w_btb_en) begin
      btb[w_btb_idx] <= w_entry;
    end
  end

  // Repair from the post-update committed history wins over fetch advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_hist   <= '0;
      commit_hist <= '0;
    end else begin
      if (upd_valid) commit_hist <= u_commit_next;
      if (upd_valid && upd_mispred)
        spec_hist <= u_commit_next;
      else if (if_advance && f_hit && f_entry.cond)
        spec_hist <= S_BHR'({spec_hist, if_pred_taken});
    end
  end

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Bench for gshare_btb_predictor. It runs directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an array-based model whose state becomes visible one edge after it is trained.
module tb_gshare_btb_predictor;
  localparam int S_BHR = 8, S_IDX = 10, S_BTB = 6, TAG_W = 8, CTR_W = 2;
  localparam int NP = 1 << S_IDX, NB = 1 << S_BTB;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      if_pc;
  logic             if_advance;
  logic [31:0]      if_pred_pc;
  logic             if_pred_taken;
  logic [S_BHR-1:0] if_pred_hist;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_next_pc;
  logic             upd_is_cond;
  logic [S_BHR-1:0] upd_hist;
  logic             upd_mispred;

  gshare_btb_predictor #(.S_BHR(S_BHR), .S_IDX(S_IDX), .S_BTB(S_BTB), .TAG_W(TAG_W), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_advance(if_advance),
    .if_pred_pc(if_pred_pc), .if_pred_taken(if_pred_taken), .if_pred_hist(if_pred_hist),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_next_pc(upd_next_pc),
    .upd_is_cond(upd_is_cond), .upd_hist(upd_hist), .upd_mispred(upd_mispred)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Model: t* is the trained state, v* is what fetch may see.
  int          tp [NP], vp [NP];
  bit          tv [NB], vv [NB], tc [NB], vc [NB];
  int unsigned tt [NB], vt [NB];
  logic [31:0] tg [NB], vg [NB];
  int unsigned m_spec, m_commit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_pred(input logic [31:0] pc, output bit hit, output bit cond,
                                 output bit tk, output logic [31:0] npc);
    int bi, pi;
    bi   = int'((pc >> 2) % NB);
    pi   = int'(((pc >> 2) ^ m_spec) % NP);
    hit  = vv[bi] && (vt[bi] == ((pc >> (S_BTB + 2)) % (1 << TAG_W)));
    cond = vc[bi];
    tk   = hit && (!cond || vp[pi] >= (1 << (CTR_W - 1)));
    npc  = tk ? vg[bi] : pc + 32'd4;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit hit, cond, tk, taken;
    logic [31:0] npc;
    int pi, bi;
    if (rst) begin
      for (int i = 0; i < NP; i++) begin tp[i] = (1 << (CTR_W - 1)) - 1; vp[i] = tp[i]; end
      for (int i = 0; i < NB; i++) begin tv[i] = 0; vv[i] = 0; end
      m_spec = 0; m_commit = 0;
    end else begin
      m_pred(if_pc, hit, cond, tk, npc);
      vp = tp; vv = tv; vt = tt; vg = tg; vc = tc;
      taken = (upd_next_pc != upd_pc + 32'd4);
      if (upd_valid) begin
        if (upd_is_cond) begin
          pi = int'(((upd_pc >> 2) ^ upd_hist) % NP);
          if (taken) tp[pi] = (tp[pi] == (1 << CTR_W) - 1) ? tp[pi] : tp[pi] + 1;
          else       tp[pi] = (tp[pi] == 0) ? 0 : tp[pi] - 1;
          m_commit = ((m_commit << 1) | int'(taken)) % (1 << S_BHR);
        end
        if (taken) begin
          bi = int'((upd_pc >> 2) % NB);
          tv[bi] = 1; tt[bi] = (upd_pc >> (S_BTB + 2)) % (1 << TAG_W);
          tg[bi] = upd_next_pc; tc[bi] = upd_is_cond;
        end
      end
      if (upd_valid && upd_mispred) m_spec = m_commit;
      else if (if_advance && hit && cond) m_spec = ((m_spec << 1) | int'(tk)) % (1 << S_BHR);
    end
  end

  always @(negedge clk) begin : compare
    bit hit, cond, tk;
    logic [31:0] npc;
    if (chk_en && !rst) begin
      m_pred(if_pc, hit, cond, tk, npc);
      check("model_pred_pc", if_pred_pc, npc);
      check("model_pred_taken", {31'd0, if_pred_taken}, {31'd0, tk});
      check("model_pred_hist", {24'd0, if_pred_hist}, m_spec);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic [31:0] npc, input logic cond,
                        input logic [S_BHR-1:0] hist, input logic mis);
    upd_valid = 1; upd_pc = pc; upd_next_pc = npc; upd_is_cond = cond; upd_hist = hist; upd_mispred = mis;
  endtask

  logic [31:0] pool [8];

  initial begin
    pool = '{32'h100, 32'h104, 32'h1000, 32'h1100, 32'h300, 32'h500, 32'h2040, 32'h80};
    rst = 1; if_pc = 32'h100; if_advance = 0;
    upd_valid = 0; upd_pc = 0; upd_next_pc = 0; upd_is_cond = 0; upd_hist = 0; upd_mispred = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0; chk_en = 1;
    #1;
    check("reset_pred_pc", if_pred_pc, 32'h104);
    check("reset_taken", {31'd0, if_pred_taken}, 32'd0);
    check("reset_hist", {24'd0, if_pred_hist}, 32'd0);

    // First training: not yet visible after one edge, visible after two
    do_upd(32'h100, 32'h80, 1, 0, 0); cyc(); upd_valid = 0; #1;
    check("train_latency_not_yet", {31'd0, if_pred_taken}, 32'd0);
    cyc(); #1;
    check("train_visible_pc", if_pred_pc, 32'h80);
    check("train_visible_taken", {31'd0, if_pred_taken}, 32'd1);

    // Back-to-back taken then one not-taken; counter ends weak taken
    do_upd(32'h100, 32'h80, 1, 0, 0); cyc();
    do_upd(32'h100, 32'h80, 1, 0, 0); cyc();
    do_upd(32'h100, 32'h104, 1, 0, 0); cyc(); upd_valid = 0; cyc(); cyc(); #1;
    check("sat_then_dec_pc", if_pred_pc, 32'h80);

    // Train history-indexed counters 0x41 and 0x43, then run the speculative history
    do_upd(32'h100, 32'h80, 1, 8'h01, 0); cyc();
    do_upd(32'h100, 32'h80, 1, 8'h03, 0); cyc(); upd_valid = 0; cyc(); cyc();
    if_advance = 1; #1;
    check("spec_hist_0", {24'd0, if_pred_hist}, 32'h0);
    cyc(); #1;
    check("spec_hist_1", {24'd0, if_pred_hist}, 32'h1);
    cyc(); #1;
    check("spec_hist_3", {24'd0, if_pred_hist}, 32'h3);
    check("spec_hist_3_taken", {31'd0, if_pred_taken}, 32'd1);
    cyc();
    // Committed so far: 1,1,1,0,1,1 then this not-taken -> 0b1110110
    do_upd(32'h100, 32'h104, 1, 8'h07, 1); cyc(); upd_valid = 0; if_advance = 0; #1;
    check("repair_hist", {24'd0, if_pred_hist}, 32'h76);

    // jal into BTB entry 0 (shared with 0x100)
    do_upd(32'h1000, 32'h2000, 0, 0, 0); cyc(); upd_valid = 0; cyc();
    if_pc = 32'h1000; if_advance = 1; #1;
    check("jal_pred_pc", if_pred_pc, 32'h2000);
    check("jal_taken", {31'd0, if_pred_taken}, 32'd1);
    cyc(); if_advance = 0; #1;
    check("jal_hist_unchanged", {24'd0, if_pred_hist}, 32'h76);
    if_pc = 32'h1100; #1;
    check("tag_mismatch_pc", if_pred_pc, 32'h1104);

    // Not-taken update on a miss leaves the entry alone
    if_pc = 32'h1000;
    do_upd(32'h300, 32'h304, 1, 0, 0); cyc(); upd_valid = 0; cyc(); cyc(); #1;
    check("nt_no_evict_pc", if_pred_pc, 32'h2000);
    if_pc = 32'h300; #1;
    check("nt_miss_pc", if_pred_pc, 32'h304);

    // Reset lands while the write is pending
    do_upd(32'h500, 32'h40, 0, 0, 0); cyc(); upd_valid = 0; #2 rst = 1;
    @(posedge clk); #1 rst = 0; if_pc = 32'h500; #1;
    check("rst_mid_pc", if_pred_pc, 32'h504);
    check("rst_mid_hist", {24'd0, if_pred_hist}, 32'h0);
    cyc(); #1;
    check("rst_mid_discarded", if_pred_pc, 32'h504);

    for (int i = 0; i < 1500; i++) begin
      if_pc = pool[$urandom_range(0, 7)];
      if_advance = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        upd_pc = pool[$urandom_range(0, 7)];
        do_upd(upd_pc, ($urandom_range(0, 2) == 0) ? upd_pc + 32'd4 : pool[$urandom_range(0, 7)],
               1'($urandom_range(0, 3) != 0), S_BHR'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      end else begin
        upd_valid = 0;
      end
      cyc();
    end
    upd_valid = 0; if_advance = 0;
    cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
